soc_spram_arbiter: RTL and testbench



---
 rtl/soc_arb_pkg.sv | 15 +
 rtl/soc_spram_arbiter_if.sv | 20 ++
 rtl/soc_arb2_sel.sv | 41 ++++
 rtl/soc_spram_arbiter.sv | 118 +++++++++++
 tb/tb_soc_spram_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_arb_pkg.sv
// Shared encodings for the SPRAM arbiter: FSM states and grant indices.
package soc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  localparam int LOCK_CW = 8;

endpackage

// File: rtl/soc_spram_arbiter_if.sv
// One requester port of the SPRAM arbiter: request/ack handshake plus command and read data.
interface soc_spram_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 32
);

  localparam int MW = DW / 8;

  logic          req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmsk;
  logic          we;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output req, addr, wdata, wmsk, we, input rdata, ack);
  modport slave  (input req, addr, wdata, wmsk, we, output rdata, ack);

endinterface

// File: rtl/soc_arb2_sel.sv
// Two-way winner selection: round-robin on ties, with a bounded burst lock for port B.
module soc_arb2_sel
  import soc_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic b_lock,
  input  logic last_grant,
  input  logic lock_nz,
  output logic gnt,
  output logic lock_load,
  output logic lock_dec,
  output logic lock_clr
);

  always_comb begin
    gnt       = GNT_A;
    lock_load = 1'b0;
    lock_dec  = 1'b0;
    lock_clr  = 1'b0;

    if (a_req && b_req) begin
      if (lock_nz && b_lock) begin
        gnt      = GNT_B;
        lock_dec = 1'b1;
      end else begin
        gnt = (last_grant == GNT_A) ? GNT_B : GNT_A;
      end
    end else if (b_req) begin
      gnt = GNT_B;
    end

    // A lone B grant under an active lock leaves the count untouched
    if (gnt == GNT_A || !b_lock) begin
      lock_clr = 1'b1;
    end else if (!lock_nz) begin
      lock_load = 1'b1;
    end
  end

endmodule

// File: rtl/soc_spram_arbiter.sv
// Shares the single-port SPRAM between the CPU bridge (port A) and the DMA mover (port B).
module soc_spram_arbiter
  import soc_arb_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 32,
  parameter int MW       = DW / 8,
  parameter int MAX_LOCK = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  soc_spram_arbiter_if.slave        a_port,
  soc_spram_arbiter_if.slave        b_port,
  input  logic                      b_lock,
  output logic [AW-1:0]             spram_addr,
  output logic [DW-1:0]             spram_wdata,
  output logic [MW-1:0]             spram_wmsk,
  output logic                      spram_we,
  input  logic [DW-1:0]             spram_rdata
);

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [LOCK_CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [MW-1:0]        wmsk_q, wmsk_d;
  logic                 we_q, we_d;

  logic sel_gnt;
  logic lock_load;
  logic lock_dec;
  logic lock_clr;

  soc_arb2_sel u_sel (
    .a_req      (a_port.req),
    .b_req      (b_port.req),
    .b_lock     (b_lock),
    .last_grant (last_grant_q),
    .lock_nz    (lock_cnt_q != '0),
    .gnt        (sel_gnt),
    .lock_load  (lock_load),
    .lock_dec   (lock_dec),
    .lock_clr   (lock_clr)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmsk_d       = wmsk_q;
    we_d         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (a_port.req || b_port.req) begin
          state_d      = ST_CMD;
          last_grant_d = sel_gnt;
          if (sel_gnt == GNT_A) begin
            addr_d  = a_port.addr;
            wdata_d = a_port.wdata;
            wmsk_d  = a_port.wmsk;
            we_d    = a_port.we;
          end else begin
            addr_d  = b_port.addr;
            wdata_d = b_port.wdata;
            wmsk_d  = b_port.wmsk;
            we_d    = b_port.we;
          end
          if (lock_load) begin
            lock_cnt_d = LOCK_CW'(MAX_LOCK - 1);
          end else if (lock_dec) begin
            lock_cnt_d = lock_cnt_q - 1'b1;
          end else if (lock_clr) begin
            lock_cnt_d = '0;
          end
        end
      end
      ST_CMD:  state_d = ST_DATA;
      ST_DATA: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_B;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmsk_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmsk_q       <= wmsk_d;
      we_q         <= we_d;
    end
  end

  assign spram_addr  = addr_q;
  assign spram_wdata = wdata_q;
  assign spram_wmsk  = wmsk_q;
  assign spram_we    = we_q;

  // last_grant_q still names the port being served while in DATA
  assign a_port.ack   = (state_q == ST_DATA) && (last_grant_q == GNT_A);
  assign b_port.ack   = (state_q == ST_DATA) && (last_grant_q == GNT_B);
  assign a_port.rdata = a_port.ack ? spram_rdata : '0;
  assign b_port.rdata = b_port.ack ? spram_rdata : '0;

endmodule

// File: tb/tb_soc_spram_arbiter.sv
// Directed bench for soc_spram_arbiter: vector table for single accesses, hand sequences for arbitration and reset.
module tb_soc_spram_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          b_lock = 1'b0;
  logic [AW-1:0] spram_addr;
  logic [DW-1:0] spram_wdata;
  logic [MW-1:0] spram_wmsk;
  logic          spram_we;
  logic [DW-1:0] spram_rdata;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  soc_spram_arbiter_if #(.AW(AW), .DW(DW)) a_if ();
  soc_spram_arbiter_if #(.AW(AW), .DW(DW)) b_if ();

  soc_spram_arbiter #(.AW(AW), .DW(DW), .MW(MW), .MAX_LOCK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_port      (a_if),
    .b_port      (b_if),
    .b_lock      (b_lock),
    .spram_addr  (spram_addr),
    .spram_wdata (spram_wdata),
    .spram_wmsk  (spram_wmsk),
    .spram_we    (spram_we),
    .spram_rdata (spram_rdata)
  );

  always #5 clk = ~clk;

  // SPRAM model: read data appears the cycle after the command, masked byte writes
  logic [31:0] mem [0:32767];
  logic [31:0] model_w;

  always @(posedge clk) begin
    spram_rdata <= mem[spram_addr];
    if (spram_we) begin
      model_w = mem[spram_addr];
      for (int i = 0; i < 4; i++) begin
        if (spram_wmsk[i]) model_w[8*i +: 8] = spram_wdata[8*i +: 8];
      end
      mem[spram_addr] = model_w;
    end
  end

  typedef struct {
    logic        port_b;
    logic [14:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmsk;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  logic grants [0:15];
  int   stamps [0:15];
  int   n_got;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    if (!v.port_b) begin
      a_if.req = 1'b1; a_if.addr = v.addr; a_if.we = v.we; a_if.wdata = v.wdata; a_if.wmsk = v.wmsk;
    end else begin
      b_if.req = 1'b1; b_if.addr = v.addr; b_if.we = v.we; b_if.wdata = v.wdata; b_if.wmsk = v.wmsk;
    end
    step();
    check_output($sformatf("v%0d_cmd_no_ack", idx), {30'b0, a_if.ack, b_if.ack}, 32'd0);
    check_output($sformatf("v%0d_cmd_addr", idx), 32'(spram_addr), 32'(v.addr));
    check_output($sformatf("v%0d_cmd_we", idx), 32'(spram_we), 32'(v.we));
    if (v.we) begin
      check_output($sformatf("v%0d_cmd_wdata", idx), spram_wdata, v.wdata);
      check_output($sformatf("v%0d_cmd_wmsk", idx), 32'(spram_wmsk), 32'(v.wmsk));
    end
    step();
    check_output($sformatf("v%0d_data_we_low", idx), 32'(spram_we), 32'd0);
    check_output($sformatf("v%0d_a_ack", idx), 32'(a_if.ack), 32'(!v.port_b));
    check_output($sformatf("v%0d_b_ack", idx), 32'(b_if.ack), 32'(v.port_b));
    if (v.chk_rd) begin
      check_output($sformatf("v%0d_rdata", idx), v.port_b ? b_if.rdata : a_if.rdata, v.exp_rd);
    end
    check_output($sformatf("v%0d_other_rdata", idx), v.port_b ? a_if.rdata : b_if.rdata, 32'd0);
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    step();
    check_output($sformatf("v%0d_single_ack", idx), {30'b0, a_if.ack, b_if.ack}, 32'd0);
  endtask

  // Runs with the current requests held, records which port is acked and when, then compares
  task automatic run_and_check_grants(input int n, input int budget, input logic [15:0] exp_bits,
                                      input string tag);
    n_got = 0;
    for (int c = 0; c < budget && n_got < n; c++) begin
      step();
      if (a_if.ack || b_if.ack) begin
        check_output($sformatf("%s_no_double_ack", tag), 32'(a_if.ack & b_if.ack), 32'd0);
        grants[n_got] = b_if.ack;
        stamps[n_got] = c;
        n_got++;
      end
    end
    check_output($sformatf("%s_ack_count", tag), 32'(n_got), 32'(n));
    for (int i = 0; i < n_got; i++) begin
      check_output($sformatf("%s_grant%0d", tag, i), 32'(grants[i]), 32'(exp_bits[i]));
      if (i > 0) begin
        check_output($sformatf("%s_spacing%0d", tag, i), 32'(stamps[i] - stamps[i-1]), 32'd3);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    logic [14:0] b2b_addr [3];
    logic [31:0] b2b_exp  [3];
    int cnt;

    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    mem[15'h0123] = 32'hDEADBEEF;

    a_if.req = 1'b0; a_if.addr = '0; a_if.wdata = '0; a_if.wmsk = '0; a_if.we = 1'b0;
    b_if.req = 1'b0; b_if.addr = '0; b_if.wdata = '0; b_if.wmsk = '0; b_if.we = 1'b0;

    vecs[0] = '{1'b0, 15'h0123, 1'b0, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 15'h7FFF, 1'b1, 32'h12345678, 4'h5, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 15'h7FFF, 1'b0, 32'h0,        4'h0, 1'b1, 32'h00340078};
    vecs[3] = '{1'b1, 15'h0123, 1'b0, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 15'h0010, 1'b1, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 15'h0010, 1'b0, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
    vecs[6] = '{1'b0, 15'h0010, 1'b1, 32'h11223344, 4'h8, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 15'h0010, 1'b0, 32'h0,        4'h0, 1'b1, 32'h11FEF00D};

    do_reset();
    check_output("rst_spram_addr",  32'(spram_addr), 32'd0);
    check_output("rst_spram_wdata", spram_wdata, 32'd0);
    check_output("rst_spram_wmsk",  32'(spram_wmsk), 32'd0);
    check_output("rst_spram_we",    32'(spram_we), 32'd0);
    check_output("rst_acks",        {30'b0, a_if.ack, b_if.ack}, 32'd0);
    check_output("rst_a_rdata",     a_if.rdata, 32'd0);
    check_output("rst_b_rdata",     b_if.rdata, 32'd0);

    for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

    // Both ports held from reset: strict alternation starting with A
    do_reset();
    a_if.req = 1'b1; a_if.addr = 15'h0123; a_if.we = 1'b0;
    b_if.req = 1'b1; b_if.addr = 15'h0010; b_if.we = 1'b0;
    run_and_check_grants(4, 40, 16'h000A, "tie");
    a_if.req = 1'b0;
    b_if.req = 1'b0;

    // Burst lock with MAX_LOCK=4, after a lone A access so B wins the first tie
    do_reset();
    apply_stimulus(8, vecs[0]);
    b_lock = 1'b1;
    a_if.req = 1'b1; a_if.addr = 15'h0123; a_if.we = 1'b0;
    b_if.req = 1'b1; b_if.addr = 15'h0010; b_if.we = 1'b0;
    run_and_check_grants(10, 60, 16'h01EF, "lock");
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    b_lock = 1'b0;

    // Asynchronous reset in the middle of the CMD cycle
    do_reset();
    a_if.req = 1'b1; a_if.addr = 15'h0050; a_if.we = 1'b1; a_if.wdata = 32'hAAAA5555; a_if.wmsk = 4'hF;
    step();
    check_output("arst_pre_we",   32'(spram_we), 32'd1);
    check_output("arst_pre_addr", 32'(spram_addr), 32'h50);
    #2;
    rst = 1'b1;
    #1;
    check_output("arst_we",    32'(spram_we), 32'd0);
    check_output("arst_addr",  32'(spram_addr), 32'd0);
    check_output("arst_wdata", spram_wdata, 32'd0);
    check_output("arst_acks",  {30'b0, a_if.ack, b_if.ack}, 32'd0);
    a_if.we = 1'b0; a_if.addr = 15'h0123;
    b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 15'h0010;
    step();
    check_output("arst_hold_acks0", {30'b0, a_if.ack, b_if.ack}, 32'd0);
    step();
    check_output("arst_hold_acks1", {30'b0, a_if.ack, b_if.ack}, 32'd0);
    rst = 1'b0;
    run_and_check_grants(1, 10, 16'h0000, "arst_tie");
    check_output("arst_a_rdata", a_if.rdata, 32'hDEADBEEF);
    a_if.req = 1'b0;
    b_if.req = 1'b0;

    // Back-to-back A with req held through each ack and the address advanced
    do_reset();
    b2b_addr[0] = 15'h0123; b2b_exp[0] = 32'hDEADBEEF;
    b2b_addr[1] = 15'h7FFF; b2b_exp[1] = 32'h00340078;
    b2b_addr[2] = 15'h0010; b2b_exp[2] = 32'h11FEF00D;
    a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = b2b_addr[0];
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!a_if.ack && cnt < 8);
      check_output($sformatf("b2b%0d_ack", k), 32'(a_if.ack), 32'd1);
      check_output($sformatf("b2b%0d_latency", k), 32'(cnt), (k == 0) ? 32'd2 : 32'd3);
      check_output($sformatf("b2b%0d_rdata", k), a_if.rdata, b2b_exp[k]);
      check_output($sformatf("b2b%0d_b_ack", k), 32'(b_if.ack), 32'd0);
      if (k < 2) a_if.addr = b2b_addr[k+1];
    end
    a_if.req = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
